// File: rtl/seg7_pkg.sv
// rtl/seg7_pkg.sv - shared types, segment patterns and helpers for the multi-digit display
package seg7_pkg;

    typedef enum logic [1:0] {IDLE, SHIFT, LATCH} state_t;

    // Lit-segment patterns, bit6..0 = g..a, before output polarity is applied.
    localparam logic [6:0] SEG_0     = 7'b0111111;
    localparam logic [6:0] SEG_1     = 7'b0000110;
    localparam logic [6:0] SEG_2     = 7'b1011011;
    localparam logic [6:0] SEG_3     = 7'b1001111;
    localparam logic [6:0] SEG_4     = 7'b1100110;
    localparam logic [6:0] SEG_5     = 7'b1101101;
    localparam logic [6:0] SEG_6     = 7'b1111101;
    localparam logic [6:0] SEG_7     = 7'b0000111;
    localparam logic [6:0] SEG_8     = 7'b1111111;
    localparam logic [6:0] SEG_9     = 7'b1101111;
    localparam logic [6:0] SEG_BLANK = 7'b0000000;
    localparam logic [6:0] SEG_DASH  = 7'b1000000;

    localparam logic [3:0] CODE_BLANK = 4'd10;
    localparam logic [3:0] CODE_DASH  = 4'd11;

    function automatic logic [31:0] pow10(input int n);
        logic [31:0] r;
        r = 32'd1;
        for (int i = 0; i < n; i++) r = r * 32'd10;
        return r;
    endfunction

endpackage

// File: rtl/seg7_digit_enc.sv
// rtl/seg7_digit_enc.sv - combinational 4-bit digit code to 7-segment pattern
module seg7_digit_enc
    import seg7_pkg::*;
#(
    parameter int ACTIVE_LOW = 1
) (
    input  logic [3:0] code,
    output logic [6:0] seg
);

    logic [6:0] pat;

    always_comb begin
        case (code)
            4'd0:       pat = SEG_0;
            4'd1:       pat = SEG_1;
            4'd2:       pat = SEG_2;
            4'd3:       pat = SEG_3;
            4'd4:       pat = SEG_4;
            4'd5:       pat = SEG_5;
            4'd6:       pat = SEG_6;
            4'd7:       pat = SEG_7;
            4'd8:       pat = SEG_8;
            4'd9:       pat = SEG_9;
            CODE_DASH:  pat = SEG_DASH;
            default:    pat = SEG_BLANK;
        endcase
        seg = (ACTIVE_LOW != 0) ? ~pat : pat;
    end

endmodule

// File: rtl/seg7_multi_display.sv
// rtl/seg7_multi_display.sv - sequential double-dabble binary to multi-digit 7-segment driver
module seg7_multi_display
    import seg7_pkg::*;
#(
    parameter int NUM_DIGITS    = 4,
    parameter int VALUE_W       = 14,
    parameter int ACTIVE_LOW    = 1,
    parameter int BLANK_LEADING = 1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    start,
    input  logic [VALUE_W-1:0]      value,
    output logic                    busy,
    output logic                    done,
    output logic                    overflow,
    output logic [7*NUM_DIGITS-1:0] seg
);

    localparam int          BCD_W = 4 * NUM_DIGITS;
    localparam int          CNT_W = $clog2(VALUE_W + 1);
    localparam logic [31:0] LIMIT = pow10(NUM_DIGITS);
    localparam logic        OFF   = (ACTIVE_LOW != 0);

    state_t                  state;
    logic [VALUE_W-1:0]      bin;
    logic [BCD_W-1:0]        bcd;
    logic [CNT_W-1:0]        cnt;
    logic                    ovf_flag;
    logic [BCD_W-1:0]        bcd_adj;
    logic [BCD_W-1:0]        codes;
    logic [7*NUM_DIGITS-1:0] seg_next;
    logic                    all_zero;

    always_comb begin
        bcd_adj = '0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            bcd_adj[4*i +: 4] = (bcd[4*i +: 4] >= 4'd5) ? bcd[4*i +: 4] + 4'd3 : bcd[4*i +: 4];
        end
    end

    // Walk from the top digit down so blanking stops at the first non-zero digit.
    always_comb begin
        codes    = '0;
        all_zero = 1'b1;
        for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
            all_zero = all_zero && (bcd[4*i +: 4] == 4'd0);
            if (ovf_flag)
                codes[4*i +: 4] = CODE_DASH;
            else if ((BLANK_LEADING != 0) && (i != 0) && all_zero)
                codes[4*i +: 4] = CODE_BLANK;
            else
                codes[4*i +: 4] = bcd[4*i +: 4];
        end
    end

    for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_enc
        seg7_digit_enc #(.ACTIVE_LOW(ACTIVE_LOW)) u_enc (
            .code (codes[4*g +: 4]),
            .seg  (seg_next[7*g +: 7])
        );
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            busy     <= 1'b0;
            done     <= 1'b0;
            overflow <= 1'b0;
            seg      <= {(7*NUM_DIGITS){OFF}};
            bin      <= '0;
            bcd      <= '0;
            cnt      <= '0;
            ovf_flag <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        bin      <= value;
                        bcd      <= '0;
                        cnt      <= '0;
                        ovf_flag <= (32'(value) >= LIMIT);
                        busy     <= 1'b1;
                        state    <= SHIFT;
                    end
                end
                SHIFT: begin
                    bcd <= {bcd_adj[BCD_W-2:0], bin[VALUE_W-1]};
                    bin <= {bin[VALUE_W-2:0], 1'b0};
                    cnt <= cnt + CNT_W'(1);
                    if (cnt == CNT_W'(VALUE_W - 1)) state <= LATCH;
                end
                LATCH: begin
                    seg      <= seg_next;
                    overflow <= ovf_flag;
                    done     <= 1'b1;
                    busy     <= 1'b0;
                    state    <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
